// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state enum and sizing for the multiply/divide unit
package mult_div_pkg;
  typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} md_state_t;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH + 1);
  function automatic int md_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on magnitudes
// ports: i_rem/i_quot/i_div = partial remainder, dividend-shifting quotient, divisor; o_rem/o_quot = next values
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);
  logic [WIDTH:0] w_sh, w_diff;
  always_comb begin
    w_sh = {i_rem, i_quot[WIDTH-1]};
    w_diff = w_sh - {1'b0, i_div};
    o_rem = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    o_quot = {i_quot[WIDTH-2:0], ~w_diff[WIDTH]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide writing the HI/LO registers
// ports: clk, reset (async high); start_mult/start_div pulses with operands a/b;
// busy, done pulse, sticky div_zero; hi/lo = product halves or remainder/quotient
module mult_div_unit import mult_div_pkg::*; #(parameter int WIDTH = MD_WIDTH) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = md_cnt_w(WIDTH);
  md_state_t r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  // multiply: {A, Q, q-1}; divide: {remainder, quotient, unused}
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_m, r_hi, r_lo, w_rem, w_quot, w_q, w_r, w_abs_a, w_abs_b;
  logic [WIDTH:0] w_pa, w_mx, w_sum;
  logic r_busy, r_done, r_dz, r_is_div, r_neg_q, r_neg_r;
  logic w_last, w_go_mult, w_go_div, w_div0;
  assign busy = r_busy;
  assign done = r_done;
  assign div_zero = r_dz;
  assign hi = r_hi;
  assign lo = r_lo;
  always_comb begin
    w_last = r_cnt == CW'(WIDTH - 1);
    w_go_mult = r_state == IDLE && start_mult;
    w_go_div = r_state == IDLE && !start_mult && start_div && b != '0;
    w_div0 = r_state == IDLE && !start_mult && start_div && b == '0;
    w_nxt = w_go_mult ? MULT :
            w_go_div ? DIV :
            r_state == FIX ? IDLE :
            (r_state == MULT || r_state == DIV) && w_last ? FIX : r_state;
    // Booth add/sub is done one bit wider so a most-negative multiplicand cannot overflow A
    w_pa = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
    w_mx = {r_m[WIDTH-1], r_m};
    w_sum = r_acc[1:0] == 2'b01 ? w_pa + w_mx :
            r_acc[1:0] == 2'b10 ? w_pa - w_mx : w_pa;
    w_q = r_acc[WIDTH:1];
    w_r = r_acc[2*WIDTH:WIDTH+1];
    w_abs_a = a[WIDTH-1] ? -a : a;
    w_abs_b = b[WIDTH-1] ? -b : b;
  end
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem(w_r),
    .i_quot(w_q),
    .i_div(r_m),
    .o_rem(w_rem),
    .o_quot(w_quot)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_m <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= w_nxt != IDLE;
      if (w_go_mult) begin
        r_acc <= {{WIDTH{1'b0}}, b, 1'b0};
        r_m <= a;
        r_is_div <= 1'b0;
        r_cnt <= '0;
        r_dz <= 1'b0;
      end else if (w_go_div) begin
        r_acc <= {{WIDTH{1'b0}}, w_abs_a, 1'b0};
        r_m <= w_abs_b;
        r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        r_neg_r <= a[WIDTH-1];
        r_is_div <= 1'b1;
        r_cnt <= '0;
        r_dz <= 1'b0;
      end else if (w_div0) begin
        r_dz <= 1'b1;
        r_done <= 1'b1;
      end else if (r_state == MULT) begin
        r_acc <= {w_sum, r_acc[WIDTH:1]};
        r_cnt <= r_cnt + CW'(1);
      end else if (r_state == DIV) begin
        r_acc <= {w_rem, w_quot, 1'b0};
        r_cnt <= r_cnt + CW'(1);
      end else if (r_state == FIX) begin
        r_hi <= r_is_div && r_neg_r ? -w_r : w_r;
        r_lo <= r_is_div && r_neg_q ? -w_q : w_q;
        r_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for the multiply/divide unit
module tb_mult_div_unit;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b1, start_mult = 1'b0, start_div = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [W-1:0] hi, lo;
  typedef struct {logic [W-1:0] hi; logic [W-1:0] lo; logic dz;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic issue(input bit sm, input bit sd, input logic [W-1:0] ia, input logic [W-1:0] ib);
    exp_t e;
    longint sa, sbv, p, q, r;
    sa = longint'($signed(ia));
    sbv = longint'($signed(ib));
    if (sm) begin
      p = sa * sbv;
      e.hi = p[63:32]; e.lo = p[31:0]; e.dz = 1'b0;
    end else if (sbv == 0) begin
      e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1;
    end else begin
      q = sa / sbv; r = sa % sbv;
      e.hi = r[31:0]; e.lo = q[31:0]; e.dz = 1'b0;
    end
    m_hi = e.hi; m_lo = e.lo;
    sb.push_back(e);
    start_mult = sm; start_div = sd; a = ia; b = ib;
  endtask

  task automatic wait_done(input int inj, output int c, output int nb);
    c = 0; nb = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 1) begin start_mult = 1'b0; start_div = 1'b0; end
      if (inj > 0 && c == inj) start_div = 1'b1;
      if (inj > 0 && c == inj + 1) start_div = 1'b0;
      if (busy) nb++;
    end while (!done && c < 200);
  endtask

  task automatic count_dones(input int n, output int k);
    k = 0;
    repeat (n) begin @(negedge clk); if (done) k++; end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, div_zero, hi, lo} !== '0) begin
      bad++; $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int c, nb; exp_t e;
    issue(1, 0, 32'hFFFF_FFFD, 32'd7);
    wait_done(0, c, nb);
    e = sb.pop_front();
    total++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB || {hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++; $display("FAIL mult_neg3x7 got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b", hi, lo, div_zero, e.hi, e.lo, e.dz);
    end
    total++;
    if (c !== 34) begin bad++; $display("FAIL mult_latency got %0d negedges want 34", c); end
    total++;
    if (nb !== 33) begin bad++; $display("FAIL mult_busy_cycles got %0d want 33", nb); end
  endtask

  task automatic test_div;
    int c, nb; exp_t e;
    issue(0, 1, -32'sd7, 32'd2);
    wait_done(0, c, nb);
    e = sb.pop_front();
    total++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD || {hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || c !== 34) begin
      bad++; $display("FAIL div_m7_2 got hi=%h lo=%h c=%0d want hi=%h lo=%h c=34", hi, lo, c, e.hi, e.lo);
    end
    issue(0, 1, 32'd7, -32'sd2);
    wait_done(0, c, nb);
    e = sb.pop_front();
    total++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD || {hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++; $display("FAIL div_7_m2 got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_div_zero;
    int c, nb; exp_t e;
    issue(0, 1, 32'd5, 32'd0);
    wait_done(0, c, nb);
    e = sb.pop_front();
    total++;
    if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || c !== 1 || nb !== 0) begin
      bad++; $display("FAIL div_zero got hi=%h lo=%h dz=%b c=%0d busy_cycles=%0d want hi=%h lo=%h dz=1 c=1 busy_cycles=0", hi, lo, div_zero, c, nb, e.hi, e.lo);
    end
    repeat (3) @(negedge clk);
    total++;
    if (div_zero !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL div_zero_sticky got dz=%b busy=%b want dz=1 busy=0", div_zero, busy);
    end
    issue(1, 0, 32'd6, -32'sd9);
    wait_done(0, c, nb);
    e = sb.pop_front();
    total++;
    if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++; $display("FAIL div_zero_clear got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=0", hi, lo, div_zero, e.hi, e.lo);
    end
  endtask

  task automatic test_corner;
    int c, nb; exp_t e;
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, c, nb);
    e = sb.pop_front();
    total++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000 || {hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++; $display("FAIL div_overflow got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
    issue(1, 0, 32'h8000_0000, 32'h8000_0000);
    wait_done(0, c, nb);
    e = sb.pop_front();
    total++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000 || {hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++; $display("FAIL mult_minmin got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_simultaneous;
    int c, nb, k; exp_t e;
    issue(1, 1, -32'sd11, 32'd13);
    wait_done(0, c, nb);
    e = sb.pop_front();
    count_dones(40, k);
    total++;
    if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || c !== 34 || k !== 0) begin
      bad++; $display("FAIL both_starts got hi=%h lo=%h c=%0d extra_done=%0d want hi=%h lo=%h c=34 extra_done=0", hi, lo, c, k, e.hi, e.lo);
    end
  endtask

  task automatic test_overlap;
    int c, nb, k; exp_t e;
    issue(1, 0, 32'd1000, -32'sd3);
    wait_done(10, c, nb);
    e = sb.pop_front();
    count_dones(40, k);
    total++;
    if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || c !== 34 || k !== 0) begin
      bad++; $display("FAIL start_while_busy got hi=%h lo=%h c=%0d extra_done=%0d want hi=%h lo=%h c=34 extra_done=0", hi, lo, c, k, e.hi, e.lo);
    end
  endtask

  task automatic test_back_to_back;
    int c, nb; exp_t e;
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      bit m;
      ra = $urandom; rb = $urandom;
      m = i[0];
      if (i == 3) rb = 32'd1;
      if (i == 6) ra = 32'h7FFF_FFFF;
      if (!m && rb == 0) rb = 32'd3;
      issue(m, !m, ra, rb);
      wait_done(0, c, nb);
      e = sb.pop_front();
      total++;
      if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || c !== 34) begin
        bad++; $display("FAIL b2b_%0d op=%s a=%h b=%h got hi=%h lo=%h c=%0d want hi=%h lo=%h c=34", i, m ? "mul" : "div", ra, rb, hi, lo, c, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_reset_mid;
    int c, nb, k; exp_t e;
    issue(0, 1, 32'd100, 32'd7);
    repeat (15) begin
      @(negedge clk);
      start_div = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, div_zero, hi, lo} !== '0) begin
      bad++; $display("FAIL reset_async got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo);
    end
    e = sb.pop_front();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    count_dones(40, k);
    total++;
    if (k !== 0) begin bad++; $display("FAIL reset_no_done got %0d dones want 0", k); end
    issue(1, 0, 32'd3, 32'd4);
    wait_done(0, c, nb);
    e = sb.pop_front();
    total++;
    if (lo !== 32'd12 || {hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++; $display("FAIL reset_then_mult got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_corner;
    test_simultaneous;
    test_overlap;
    test_back_to_back;
    test_reset_mid;
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
